// File: rtl/keypad_scanner_param.sv
// Row-scanning keypad controller: drives one row low at a time, debounces the
// first closed column, and reports accepted keys with optional auto-repeat.
module keypad_scanner_param #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SETTLE_CYC   = 2,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int REPEAT_CYC   = 0,
    parameter int DIGITS       = 2,
    localparam int KW          = $clog2(ROWS * COLS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [COLS-1:0]      col_sync,
    output logic [ROWS-1:0]      r_sel,
    output logic                 key_valid,
    output logic [KW-1:0]        key_idx,
    output logic                 key_held,
    output logic [DIGITS*KW-1:0] digits,
    output logic [2:0]           dbg_state
);

    localparam int RW     = $clog2(ROWS);
    localparam int CW     = $clog2(COLS);
    localparam int MAX_DR = (DEBOUNCE_CYC > REPEAT_CYC) ? DEBOUNCE_CYC : REPEAT_CYC;
    localparam int MAXC   = (MAX_DR > SETTLE_CYC) ? MAX_DR : SETTLE_CYC;
    localparam int CNTW   = $clog2(MAXC + 1);

    localparam logic [CNTW-1:0] SET_LAST = CNTW'(SETTLE_CYC - 1);
    localparam logic [CNTW-1:0] DEB_LAST = CNTW'(DEBOUNCE_CYC - 1);
    localparam logic [CNTW-1:0] REL_LAST = CNTW'(DEBOUNCE_CYC - 2);
    localparam logic [CNTW-1:0] REP_LAST = CNTW'((REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0);

    typedef enum logic [2:0] {
        SCAN     = 3'd0,
        SETTLE   = 3'd1,
        DEBOUNCE = 3'd2,
        HELD     = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    state_t               state;
    logic [RW-1:0]        row;
    logic [RW-1:0]        row_next;
    logic [CNTW-1:0]      cnt;
    logic [COLS-1:0]      cap_pat;
    logic [CW-1:0]        cap_col;
    logic [COLS-1:0]      low_pat;
    logic [CW-1:0]        low_col;
    logic [KW-1:0]        key_new;
    logic [DIGITS*KW-1:0] digits_sh;

    function automatic logic [ROWS-1:0] row_drive(input logic [RW-1:0] r);
        row_drive    = '1;
        row_drive[r] = 1'b0;
    endfunction

    // Lowest-index closed column wins; any extra closed columns later abort debounce.
    always_comb begin
        low_pat = '0;
        low_col = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (col_sync[c]) begin
                low_pat    = '0;
                low_pat[c] = 1'b1;
                low_col    = CW'(c);
            end
        end
    end

    always_comb begin
        row_next  = (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
        key_new   = KW'(row) * KW'(COLS) + KW'(cap_col);
        digits_sh = digits << KW;
        digits_sh[KW-1:0] = key_new;
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            row       <= '0;
            r_sel     <= row_drive('0);
            cnt       <= '0;
            cap_pat   <= '0;
            cap_col   <= '0;
            key_valid <= 1'b0;
            key_idx   <= '0;
            key_held  <= 1'b0;
            digits    <= '0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    cnt <= '0;
                    if (col_sync == '0) begin
                        state <= SETTLE;
                    end else begin
                        cap_pat <= low_pat;
                        cap_col <= low_col;
                        state   <= DEBOUNCE;
                    end
                end
                SETTLE: begin
                    if (cnt == SET_LAST) begin
                        cnt   <= '0;
                        row   <= row_next;
                        r_sel <= row_drive(row_next);
                        state <= SCAN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (col_sync != cap_pat) begin
                        cnt   <= '0;
                        state <= SCAN;
                    end else if (cnt == DEB_LAST) begin
                        key_valid <= 1'b1;
                        key_idx   <= key_new;
                        digits    <= digits_sh;
                        key_held  <= 1'b1;
                        cnt       <= '0;
                        state     <= HELD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (col_sync == '0) begin
                        cnt   <= '0;
                        state <= RELEASE;
                    end else if (REPEAT_CYC > 0) begin
                        if (cnt == REP_LAST) begin
                            key_valid <= 1'b1;
                            key_idx   <= key_new;
                            digits    <= digits_sh;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    // The HELD cycle that first saw the columns open counts as quiet cycle one.
                    if (col_sync != '0) begin
                        cnt   <= '0;
                        state <= HELD;
                    end else if (cnt == REL_LAST) begin
                        key_held <= 1'b0;
                        cnt      <= '0;
                        state    <= SETTLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner_param.sv
// Directed bench for keypad_scanner_param: a 4x4 keypad model feeds the column
// senses from the driven row; a second instance exercises auto-repeat.
module tb_keypad_scanner_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] press;
    logic [15:0] press_rep;
    logic        kill;

    logic [3:0] col_sync, r_sel, key_idx;
    logic       key_valid, key_held;
    logic [7:0] digits;
    logic [2:0] dbg_state;

    logic [3:0] col_rep, r_sel_rep, key_idx_rep;
    logic       key_valid_rep, key_held_rep;
    logic [7:0] digits_rep;
    logic [2:0] dbg_state_rep;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    keypad_scanner_param #(
        .ROWS(4), .COLS(4), .SETTLE_CYC(2), .DEBOUNCE_CYC(8), .REPEAT_CYC(0), .DIGITS(2)
    ) dut (
        .clk(clk), .reset(reset), .col_sync(col_sync), .r_sel(r_sel),
        .key_valid(key_valid), .key_idx(key_idx), .key_held(key_held),
        .digits(digits), .dbg_state(dbg_state)
    );

    keypad_scanner_param #(
        .ROWS(4), .COLS(4), .SETTLE_CYC(2), .DEBOUNCE_CYC(8), .REPEAT_CYC(10), .DIGITS(2)
    ) dut_rep (
        .clk(clk), .reset(reset), .col_sync(col_rep), .r_sel(r_sel_rep),
        .key_valid(key_valid_rep), .key_idx(key_idx_rep), .key_held(key_held_rep),
        .digits(digits_rep), .dbg_state(dbg_state_rep)
    );

    // Keypad model: a pressed key closes its column only while its row is driven low.
    function automatic logic [3:0] cols(input logic [15:0] pressed, input logic [3:0] rs,
                                        input logic k);
        logic [3:0] v;
        v = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !rs[r]) v[c] = 1'b1;
        return k ? 4'b0000 : v;
    endfunction

    assign col_sync = cols(press, r_sel, kill);
    assign col_rep  = cols(press_rep, r_sel_rep, 1'b0);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Releases key k at a HELD cycle; key_held must fall exactly 8 cycles later.
    task automatic rel(input int k);
        step();
        press[k] = 1'b0;
        repeat (7) step();
        check("rel_held_still", key_held, 1);
        step();
        check("rel_held_fall", key_held, 0);
    endtask

    task automatic press_key(input int k, input logic [7:0] exp_digits);
        logic got;
        got = 1'b0;
        press[k] = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (key_valid) got = 1'b1;
        end
        check("key_seen", got, 1);
        check("key_idx", key_idx, k);
        check("key_digits", digits, exp_digits);
        rel(k);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [3:0] e;
        int         pulses;
        logic       got;

        reset = 1'b1; press = '0; press_rep = '0; kill = 1'b0;
        repeat (3) step();
        check("rst_r_sel", r_sel, 4'b1110);
        check("rst_valid", key_valid, 0);
        check("rst_idx", key_idx, 0);
        check("rst_held", key_held, 0);
        check("rst_digits", digits, 0);
        reset = 1'b0;

        // Idle scan: three cycles per row, cycles 0..12.
        for (int k = 0; k <= 12; k++) begin
            e = ~(4'b0001 << ((k / 3) % 4));
            check("idle_r_sel", r_sel, e);
            check("idle_valid", key_valid, 0);
            step();
        end

        // Key 6 pressed at cycle 13; row 1 scanned at 15, accepted at 24.
        press[6] = 1'b1;
        for (int c = 13; c <= 23; c++) begin
            check("k6_no_early", key_valid, 0);
            step();
        end
        check("k6_valid", key_valid, 1);
        check("k6_idx", key_idx, 6);
        check("k6_digits", digits, 8'h06);
        check("k6_held", key_held, 1);
        for (int c = 25; c <= 43; c++) begin
            step();
            check("k6_no_repeat", key_valid, 0);
        end
        rel(6);
        check("k6_idx_kept", key_idx, 6);
        check("k6_digits_kept", digits, 8'h06);

        // Now cycle 52; row 0 scanned at 60, bounce at 64, rescan at 65, accept at 74.
        press[0] = 1'b1;
        for (int c = 52; c <= 73; c++) begin
            kill = (c == 64);
            if (c == 65) check("bounce_row_frozen", r_sel, 4'b1110);
            check("bounce_no_event", key_valid, 0);
            step();
        end
        kill = 1'b0;
        check("k0_valid", key_valid, 1);
        check("k0_idx", key_idx, 0);
        check("k0_digits", digits, 8'h60);
        rel(0);

        press_key(5, 8'h05);
        press_key(11, 8'h5b);
        press_key(3, 8'hb3);

        // Reset in the middle of a debounce.
        reset = 1'b1; press[0] = 1'b1;
        step();
        reset = 1'b0;
        repeat (4) step();
        reset = 1'b1; press[0] = 1'b0;
        step();
        check("rd_valid", key_valid, 0);
        check("rd_idx", key_idx, 0);
        check("rd_held", key_held, 0);
        check("rd_digits", digits, 0);
        check("rd_r_sel", r_sel, 4'b1110);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            check("rd_no_event", key_valid, 0);
        end

        // Reset while held: key 1 accepted 9 cycles after the first scan.
        reset = 1'b1;
        step();
        reset = 1'b0; press[1] = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            check("rh_no_early", key_valid, 0);
            step();
        end
        check("rh_valid", key_valid, 1);
        check("rh_idx", key_idx, 1);
        check("rh_digits", digits, 8'h01);
        step(); step();
        reset = 1'b1; press[1] = 1'b0;
        step();
        check("rh_valid0", key_valid, 0);
        check("rh_idx0", key_idx, 0);
        check("rh_held0", key_held, 0);
        check("rh_digits0", digits, 0);
        check("rh_r_sel", r_sel, 4'b1110);
        reset = 1'b0;

        // Auto-repeat instance: key 15, pulses every 10 held cycles.
        press_rep[15] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (key_valid_rep) got = 1'b1;
        end
        check("rep_seen", got, 1);
        check("rep_idx", key_idx_rep, 15);
        check("rep_digits_first", digits_rep, 8'h0f);
        pulses = 1;
        for (int i = 1; i <= 35; i++) begin
            step();
            check("rep_pulse_timing", key_valid_rep, (i % 10) == 0);
            if (key_valid_rep) begin
                pulses++;
                check("rep_pulse_idx", key_idx_rep, 15);
            end
        end
        check("rep_pulse_count", pulses, 4);
        check("rep_digits", digits_rep, 8'hff);
        check("rep_held", key_held_rep, 1);
        press_rep[15] = 1'b0;
        repeat (12) step();
        check("rep_released", key_held_rep, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
